// File: rtl/vga_pkg.sv
// 640x480@60 timing constants, framebuffer geometry and shared types for vga_pixel_gen.
package vga_pkg;

    // Horizontal timing, in pixel clocks
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;

    // Vertical timing, in lines
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;

    // Active window edges in sync-generator counter space
    localparam int H_ACT_START = H_SYNC + H_BP;
    localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
    localparam int V_ACT_START = V_SYNC + V_BP;
    localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

    // Quarter-resolution framebuffer
    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int FB_DEPTH = FB_W * FB_H;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } sprite_pos_t;

    // Each framebuffer word covers a 4x4 block of screen pixels.
    function automatic logic [14:0] fb_index(input logic [9:0] x, input logic [9:0] y);
        logic [14:0] row;
        logic [14:0] col;
        row = 15'(y >> 2);
        col = 15'(x >> 2);
        return row * 15'(FB_W) + col;
    endfunction

endpackage

// File: rtl/vga_sprite_pos.sv
// Sprite position handshake: one-deep pending register, committed to the live
// position only at the frame commit point so a frame never shows two positions.
module vga_sprite_pos
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pos_valid,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic        commit,
    output logic        pos_ready,
    output sprite_pos_t spr_pos
);

    sprite_pos_t pend;
    logic        pend_full;
    logic        accept;

    assign pos_ready = !pend_full;
    assign accept    = pos_valid && pos_ready;

    // Commit drains a full pending slot; an accept can only land when the slot is
    // empty, so an accept in the commit cycle simply waits for the next commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend      <= '0;
            pend_full <= 1'b0;
            spr_pos   <= '0;
        end else if (commit && pend_full) begin
            spr_pos   <= pend;
            pend_full <= 1'b0;
        end else if (accept) begin
            pend      <= '{x: pos_x, y: pos_y};
            pend_full <= 1'b1;
        end
    end

endmodule

// File: rtl/vga_pixel_gen.sv
// VGA pixel generator: framebuffer fetch plus optional single-colour sprite overlay,
// fixed two-cycle latency from counters/syncs to RGB/sync outputs.
// Sprite overlay is compiled in with `define VGA_PIXEL_GEN_SPRITE_EN.
module vga_pixel_gen
    import vga_pkg::*;
#(
    parameter logic [11:0] SPRITE_COLOR = 12'hF00,
    parameter int          SPRITE_SIZE  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  h_count,
    input  logic [9:0]  v_count,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [14:0] fb_addr,
    input  logic [11:0] fb_data,
    input  logic        pos_valid,
    output logic        pos_ready,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    localparam int STAGES = 1;

    logic              in_active;
    logic [9:0]        x;
    logic [9:0]        y;
    logic              commit;
    logic              spr_hit;
    logic [STAGES:0]   vld_pipe;
    logic [STAGES:0]   hs_pipe;
    logic [STAGES:0]   vs_pipe;
    logic              hit_q;
    rgb444_t           rgb_q;

    assign in_active = (h_count >= 10'(H_ACT_START)) && (h_count < 10'(H_ACT_END)) &&
                       (v_count >= 10'(V_ACT_START)) && (v_count < 10'(V_ACT_END));
    assign x         = h_count - 10'(H_ACT_START);
    assign y         = v_count - 10'(V_ACT_START);
    // First pixel clock of the first blanking line after the active area
    assign commit    = (h_count == 10'd0) && (v_count == 10'(V_ACT_END));

`ifdef VGA_PIXEL_GEN_SPRITE_EN
    sprite_pos_t spr_pos;
    logic [10:0] x11;
    logic [10:0] y11;
    logic [10:0] px11;
    logic [10:0] py11;

    vga_sprite_pos u_sprite_pos (
        .clk       (clk),
        .rst_n     (rst_n),
        .pos_valid (pos_valid),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .commit    (commit),
        .pos_ready (pos_ready),
        .spr_pos   (spr_pos)
    );

    // 11-bit compare so a sprite near 1023 cannot wrap onto the left/top edge
    assign x11     = {1'b0, x};
    assign y11     = {1'b0, y};
    assign px11    = {1'b0, spr_pos.x};
    assign py11    = {1'b0, spr_pos.y};
    assign spr_hit = (x11 >= px11) && (x11 < px11 + 11'(SPRITE_SIZE)) &&
                     (y11 >= py11) && (y11 < py11 + 11'(SPRITE_SIZE));
`else
    logic unused_sprite;

    assign pos_ready     = 1'b1;
    assign spr_hit       = 1'b0;
    assign unused_sprite = ^{pos_valid, pos_x, pos_y, commit};
`endif

    // Control pipe: active and raw syncs shifted alongside the pixel data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            hs_pipe  <= '1;
            vs_pipe  <= '1;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], in_active};
            hs_pipe  <= {hs_pipe[STAGES-1:0], hsync_in};
            vs_pipe  <= {vs_pipe[STAGES-1:0], vsync_in};
        end
    end

    // Data pipe: address/hit in the first rank, final colour select in the second
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fb_addr <= '0;
            hit_q   <= 1'b0;
            rgb_q   <= '0;
        end else begin
            fb_addr <= in_active ? fb_index(x, y) : '0;
            hit_q   <= spr_hit;
            if (!vld_pipe[0])
                rgb_q <= '0;
            else if (hit_q)
                rgb_q <= rgb444_t'(SPRITE_COLOR);
            else
                rgb_q <= rgb444_t'(fb_data);
        end
    end

    assign active = vld_pipe[STAGES];
    assign hsync  = hs_pipe[STAGES];
    assign vsync  = vs_pipe[STAGES];
    assign red    = rgb_q.r;
    assign green  = rgb_q.g;
    assign blue   = rgb_q.b;

endmodule

// File: doc/vga_pixel_gen.md
VGA_PIXEL_GEN -- requirements
Module: vga_pixel_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, ports named clk and rst_n.
REQ-002 Parameter SPRITE_COLOR, default 12'hF00, SHALL set the sprite RGB444 colour.
REQ-003 Parameter SPRITE_SIZE, default 16, SHALL set the sprite edge length in pixels.
REQ-004 Ports SHALL be, one per line (name  direction  width  meaning):
- clk  in  1  pixel clock (25 MHz)
- rst_n  in  1  synchronous active-low reset
- h_count  in  10  horizontal counter from sync generator, 0..799
- v_count  in  10  vertical counter from sync generator, 0..524
- hsync_in  in  1  raw hsync, low while h_count<96
- vsync_in  in  1  raw vsync, low while v_count<2
- fb_addr  out  15  framebuffer read address, 160x120 RGB444
- fb_data  in  12  framebuffer word, valid 1 cycle after fb_addr
- pos_valid  in  1  sprite position update request
- pos_ready  out  1  update accepted when pos_valid&pos_ready
- pos_x  in  10  new sprite left edge, active-area pixels
- pos_y  in  10  new sprite top edge, active-area pixels
- hsync  out  1  hsync aligned with RGB
- vsync  out  1  vsync aligned with RGB
- active  out  1  pixel in active area, aligned with RGB
- red, green, blue  out  4 each  pixel colour

Function
REQ-005 Active area SHALL be 144<=h_count<784 and 35<=v_count<515; x=h_count-144, y=v_count-35.
REQ-006 Stage 0 SHALL register fb_addr=(y>>2)*160+(x>>2) in active area, else hold 0.
REQ-007 Stage 1 SHALL register fb_data, the sprite-hit flag and the delayed active/hsync/vsync.
REQ-008 Stage 2 SHALL register outputs; total latency input->hsync/vsync/active/RGB SHALL be exactly 2 cycles.
REQ-009 RGB SHALL be 0 when the delayed active is 0, SPRITE_COLOR on sprite hit, else fb_data.
REQ-010 Sprite hit SHALL be px<=x<px+SPRITE_SIZE and py<=y<py+SPRITE_SIZE, compared at 11 bits (no wrap); off-screen parts are clipped.
REQ-011 The pending-update register SHALL be empty at reset; pos_ready=1 iff the register is empty.
REQ-012 On pos_valid&pos_ready, pos_x/pos_y SHALL be latched into the pending register; pos_ready SHALL drop the next cycle.
REQ-013 Commit point SHALL be h_count==0 && v_count==515; if pending is full, the active position SHALL load from it and pending SHALL clear; pos_ready SHALL return to 1 the next cycle.
REQ-014 An accept coinciding with the commit cycle SHALL be held pending until the next frame's commit.
REQ-015 The active sprite position SHALL never change outside the commit point (no tearing).

Reset
REQ-016 While rst_n=0 at a clk edge: RGB=0, active=0, hsync=1, vsync=1, fb_addr=0, pos_ready=1, sprite position=(0,0), pending cleared, pipeline cleared.
REQ-017 Reset mid-frame SHALL discard any pending update; output SHALL resume correctly 2 cycles after release.

Configuration
REQ-018 Macro VGA_PIXEL_GEN_SPRITE_EN SHALL compile in the sprite logic (REQ-010..015).
REQ-019 Without VGA_PIXEL_GEN_SPRITE_EN, pos_ready SHALL be tied to 1, pos_* inputs SHALL be ignored, and RGB SHALL be fb_data or 0; latency SHALL be unchanged.

Structure
REQ-020 Package vga_pkg SHALL hold the 640x480 timing constants (sync 96/2, porches 48,16/33,10, active 640/480), FB_W=160, FB_H=120 and the RGB444 typedef.
REQ-021 Sub-module vga_sprite_pos (handshake + pending/commit registers) SHALL be instantiated only under the macro.

Verification
REQ-022 h=144,v=35 at cycle t -> fb_addr=0 at t+1; fb_data=12'h0A5 at t+1 -> RGB=0/A/5, active=1 at t+2.
REQ-023 h=783,v=514 -> fb_addr=119*160+159=19199; h=784 -> active=0 and RGB=0 two cycles later.
REQ-024 h_count<96 -> hsync=0 exactly 2 cycles later; v_count=1 -> vsync=0 two cycles later.
REQ-025 pos_valid with (100,50) mid-frame -> sprite stays (0,0) until commit; after commit, pixel (100,50) is F00 and (116,50) is fb_data; pos_ready is 1 again.
REQ-026 Second pos_valid while pending -> pos_ready=0, no accept; accept at the commit cycle -> applied one frame later.
REQ-027 Pulse rst_n low mid-frame with pending (200,200) -> sprite remains (0,0) after the next commit; outputs match REQ-016.
